// File: rtl/decode.sv
// decode: RV64I decode stage; registers one decoded beat (with operand bypass) for execute.
// Build option DECODE_SKID_EN: adds a 1-entry raw {instr,PC} skid buffer and makes the
// fetch retry a flop; without it the fetch retry is a combinational back-pressure term.
module decode #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned INSTR_W = 32,
    localparam int unsigned REG_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [XLEN-1:0]    fetch_PC,
    output logic               decode_ack_fetch_retry,
    input  logic               flush,
    output logic [REG_W-1:0]   rf_rs1_sel,
    output logic [REG_W-1:0]   rf_rs2_sel,
    input  logic [XLEN-1:0]    rf_rs1_data,
    input  logic [XLEN-1:0]    rf_rs2_data,
    input  logic [REG_W-1:0]   wb_rd_sel,
    input  logic               wb_dest_enable,
    input  logic [XLEN-1:0]    wb_dest,
    output logic               decode_ack_data_valid,
    input  logic               execute_ack_data_rety,
    output logic [REG_W-1:0]   decode_dest_sel,
    output logic               imm_rs2_sel,
    output logic               comp_is_unsigned,
    output logic [XLEN-1:0]    sign_ex_imm,
    output logic [5:0]         shift_amount,
    output logic [19:0]        U_imm,
    output logic [19:0]        UJ_imm,
    output logic [11:0]        SB_imm,
    output logic [6:0]         op_code,
    output logic [2:0]         funct3,
    output logic [6:0]         funct7,
    output logic [XLEN-1:0]    PC,
    output logic [XLEN-1:0]    src1,
    output logic [XLEN-1:0]    src2
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    logic               load_en_c;    // output register may take a new beat
    logic               dec_valid_c;  // selected source carries a beat to keep
    logic [INSTR_W-1:0] dec_instr_c;
    logic [XLEN-1:0]    dec_pc_c;
    logic [REG_W-1:0]   rs1_c, rs2_c;
    logic [XLEN-1:0]    opnd1_c, opnd2_c;

    logic               valid_q, valid_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    logic               imm_sel_q, imm_sel_d;
    logic               unsigned_q, unsigned_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [5:0]         shamt_q, shamt_d;
    logic [19:0]        u_imm_q, u_imm_d;
    logic [19:0]        uj_imm_q, uj_imm_d;
    logic [11:0]        sb_imm_q, sb_imm_d;
    logic [6:0]         op_q, op_d;
    logic [2:0]         f3_q, f3_d;
    logic [6:0]         f7_q, f7_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    src1_q, src1_d;
    logic [XLEN-1:0]    src2_q, src2_d;

    assign load_en_c = ~valid_q | ~execute_ack_data_rety;

`ifdef DECODE_SKID_EN
    logic               skid_full_q, skid_full_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]    skid_pc_q, skid_pc_d;
    logic               accept_c;

    assign decode_ack_fetch_retry = skid_full_q;
    assign accept_c    = fetch_valid & ~skid_full_q & ~flush;
    assign dec_instr_c = skid_full_q ? skid_instr_q : fetch_instr;
    assign dec_pc_c    = skid_full_q ? skid_pc_q : fetch_PC;
    assign dec_valid_c = skid_full_q ? ~flush : accept_c;

    // Skid fills when a beat is accepted while the output register is stalled; drains first
    always_comb begin
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            if (load_en_c) skid_full_d = 1'b0;
        end else if (accept_c && !load_en_c) begin
            skid_full_d  = 1'b1;
            skid_instr_d = fetch_instr;
            skid_pc_d    = fetch_PC;
        end
    end

    // Skid buffer state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full_q  <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
`else
    assign decode_ack_fetch_retry = valid_q & execute_ack_data_rety;
    assign dec_instr_c = fetch_instr;
    assign dec_pc_c    = fetch_PC;
    assign dec_valid_c = fetch_valid & ~decode_ack_fetch_retry & ~flush;
`endif

    assign rs1_c      = dec_instr_c[19:15];
    assign rs2_c      = dec_instr_c[24:20];
    assign rf_rs1_sel = rs1_c;
    assign rf_rs2_sel = rs2_c;

    // Operand select: x0 is zero, same-cycle writeback wins over the register file
    assign opnd1_c = (rs1_c == '0) ? '0 :
                     (wb_dest_enable && (wb_rd_sel == rs1_c)) ? wb_dest : rf_rs1_data;
    assign opnd2_c = (rs2_c == '0) ? '0 :
                     (wb_dest_enable && (wb_rd_sel == rs2_c)) ? wb_dest : rf_rs2_data;

    // Decode the selected beat into the output register's next state
    always_comb begin
        valid_d    = valid_q;
        dest_d     = dest_q;
        imm_sel_d  = imm_sel_q;
        unsigned_d = unsigned_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        u_imm_d    = u_imm_q;
        uj_imm_d   = uj_imm_q;
        sb_imm_d   = sb_imm_q;
        op_d       = op_q;
        f3_d       = f3_q;
        f7_d       = f7_q;
        pc_d       = pc_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        if (load_en_c) begin
            valid_d = dec_valid_c;
            if (dec_valid_c) begin
                op_d     = dec_instr_c[6:0];
                f3_d     = dec_instr_c[14:12];
                f7_d     = dec_instr_c[31:25];
                imm_d    = {{(XLEN-12){dec_instr_c[31]}}, dec_instr_c[31:20]};
                u_imm_d  = dec_instr_c[31:12];
                uj_imm_d = {dec_instr_c[31], dec_instr_c[19:12], dec_instr_c[20], dec_instr_c[30:21]};
                sb_imm_d = {dec_instr_c[31], dec_instr_c[7], dec_instr_c[30:25], dec_instr_c[11:8]};
                shamt_d  = dec_instr_c[25:20];
                if (dec_instr_c[6:0] == OPC_OP_IMM_32) shamt_d[5] = 1'b0;
                pc_d     = dec_pc_c;
                src1_d   = opnd1_c;
                src2_d   = opnd2_c;
                unique case (dec_instr_c[6:0])
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE,
                    OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32:
                        dest_d = dec_instr_c[11:7];
                    default: dest_d = '0;
                endcase
                imm_sel_d  = (dec_instr_c[6:0] == OPC_OP_IMM) ||
                             (dec_instr_c[6:0] == OPC_OP_IMM_32) ||
                             (dec_instr_c[6:0] == OPC_JALR);
                unsigned_d = (((dec_instr_c[6:0] == OPC_OP) || (dec_instr_c[6:0] == OPC_OP_IMM)) &&
                              (dec_instr_c[14:12] == 3'b011)) ||
                             ((dec_instr_c[6:0] == OPC_BRANCH) && (dec_instr_c[14:13] == 2'b11));
            end
        end
    end

    // Output register toward execute
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            dest_q     <= '0;
            imm_sel_q  <= 1'b0;
            unsigned_q <= 1'b0;
            imm_q      <= '0;
            shamt_q    <= '0;
            u_imm_q    <= '0;
            uj_imm_q   <= '0;
            sb_imm_q   <= '0;
            op_q       <= '0;
            f3_q       <= '0;
            f7_q       <= '0;
            pc_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            dest_q     <= dest_d;
            imm_sel_q  <= imm_sel_d;
            unsigned_q <= unsigned_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            u_imm_q    <= u_imm_d;
            uj_imm_q   <= uj_imm_d;
            sb_imm_q   <= sb_imm_d;
            op_q       <= op_d;
            f3_q       <= f3_d;
            f7_q       <= f7_d;
            pc_q       <= pc_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
        end
    end

    assign decode_ack_data_valid = valid_q;
    assign decode_dest_sel       = dest_q;
    assign imm_rs2_sel           = imm_sel_q;
    assign comp_is_unsigned      = unsigned_q;
    assign sign_ex_imm           = imm_q;
    assign shift_amount          = shamt_q;
    assign U_imm                 = u_imm_q;
    assign UJ_imm                = uj_imm_q;
    assign SB_imm                = sb_imm_q;
    assign op_code               = op_q;
    assign funct3                = f3_q;
    assign funct7                = f7_q;
    assign PC                    = pc_q;
    assign src1                  = src1_q;
    assign src2                  = src2_q;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed, self-checking bench for the decode stage (either build of DECODE_SKID_EN).
module tb_decode;

`ifdef DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [63:0] fetch_PC;
    logic        decode_ack_fetch_retry;
    logic        flush;
    logic [4:0]  rf_rs1_sel, rf_rs2_sel;
    logic [63:0] rf_rs1_data, rf_rs2_data;
    logic [4:0]  wb_rd_sel;
    logic        wb_dest_enable;
    logic [63:0] wb_dest;
    logic        decode_ack_data_valid;
    logic        execute_ack_data_rety;
    logic [4:0]  decode_dest_sel;
    logic        imm_rs2_sel;
    logic        comp_is_unsigned;
    logic [63:0] sign_ex_imm;
    logic [5:0]  shift_amount;
    logic [19:0] U_imm, UJ_imm;
    logic [11:0] SB_imm;
    logic [6:0]  op_code, funct7;
    logic [2:0]  funct3;
    logic [63:0] PC, src1, src2;

    logic [63:0] rf [32];
    int          checks;
    int          failures;

    decode dut (
        .clk                    (clk),
        .reset                  (reset),
        .fetch_valid            (fetch_valid),
        .fetch_instr            (fetch_instr),
        .fetch_PC               (fetch_PC),
        .decode_ack_fetch_retry (decode_ack_fetch_retry),
        .flush                  (flush),
        .rf_rs1_sel             (rf_rs1_sel),
        .rf_rs2_sel             (rf_rs2_sel),
        .rf_rs1_data            (rf_rs1_data),
        .rf_rs2_data            (rf_rs2_data),
        .wb_rd_sel              (wb_rd_sel),
        .wb_dest_enable         (wb_dest_enable),
        .wb_dest                (wb_dest),
        .decode_ack_data_valid  (decode_ack_data_valid),
        .execute_ack_data_rety  (execute_ack_data_rety),
        .decode_dest_sel        (decode_dest_sel),
        .imm_rs2_sel            (imm_rs2_sel),
        .comp_is_unsigned       (comp_is_unsigned),
        .sign_ex_imm            (sign_ex_imm),
        .shift_amount           (shift_amount),
        .U_imm                  (U_imm),
        .UJ_imm                 (UJ_imm),
        .SB_imm                 (SB_imm),
        .op_code                (op_code),
        .funct3                 (funct3),
        .funct7                 (funct7),
        .PC                     (PC),
        .src1                   (src1),
        .src2                   (src2)
    );

    // Combinational register-file model
    assign rf_rs1_data = rf[rf_rs1_sel];
    assign rf_rs2_data = rf[rf_rs2_sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat for one cycle, then leave the outputs showing it
    task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
        fetch_valid = 1'b1;
        fetch_instr = instr;
        fetch_PC    = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    logic [31:0] beat_instr [3];
    logic [63:0] beat_pc [3];
    int          idx_f, idx_e;
    logic        fire_f, fire_e;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_PC = '0;
        flush = 1'b0;
        wb_rd_sel = '0;
        wb_dest_enable = 1'b0;
        wb_dest = '0;
        execute_ack_data_rety = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 64'h100 + 64'(i);
        rf[0] = 64'h0;
        rf[1] = 64'd7;
        rf[2] = 64'h20;
        rf[3] = 64'h0;

        // Reset state
        step();
        step();
        check("rst_valid", 64'(decode_ack_data_valid), 64'd0);
        check("rst_retry", 64'(decode_ack_fetch_retry), 64'd0);
        check("rst_pc", PC, 64'd0);
        check("rst_imm", sign_ex_imm, 64'd0);
        check("rst_dest", 64'(decode_dest_sel), 64'd0);
        reset = 1'b1;
        step();

        // ADDI x5,x1,-1
        issue(32'hFFF08293, 64'h100);
        check("addi_valid", 64'(decode_ack_data_valid), 64'd1);
        check("addi_op", 64'(op_code), 64'h13);
        check("addi_imm", sign_ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_immsel", 64'(imm_rs2_sel), 64'd1);
        check("addi_dest", 64'(decode_dest_sel), 64'd5);
        check("addi_src1", src1, 64'd7);
        check("addi_pc", PC, 64'h100);
        check("addi_shamt", 64'(shift_amount), 64'h3F);
        step();
        check("idle_valid", 64'(decode_ack_data_valid), 64'd0);

        // JAL x1,+2048
        issue(32'h001000EF, 64'h1000);
        check("jal_ujimm", 64'(UJ_imm), 64'h00400);
        check("jal_dest", 64'(decode_dest_sel), 64'd1);
        check("jal_immsel", 64'(imm_rs2_sel), 64'd0);
        check("jal_pc", PC, 64'h1000);

        // BLTU x1,x2,+16
        issue(32'h0020E863, 64'h1004);
        check("bltu_unsigned", 64'(comp_is_unsigned), 64'd1);
        check("bltu_sbimm", 64'(SB_imm), 64'h008);
        check("bltu_dest", 64'(decode_dest_sel), 64'd0);
        check("bltu_funct3", 64'(funct3), 64'd6);
        check("bltu_src2", src2, 64'h20);

        // SLLIW x6,x1,35-style encoding: shamt bit5 must clear
        issue(32'h0230931B, 64'h1008);
        check("slliw_shamt", 64'(shift_amount), 64'h03);
        check("slliw_immsel", 64'(imm_rs2_sel), 64'd1);
        check("slliw_funct7", 64'(funct7), 64'd1);
        check("slliw_imm", sign_ex_imm, 64'h23);

        // SLTIU x7,x1,5
        issue(32'h0050B393, 64'h100C);
        check("sltiu_unsigned", 64'(comp_is_unsigned), 64'd1);
        check("sltiu_dest", 64'(decode_dest_sel), 64'd7);

        // LUI x8,0x12345
        issue(32'h12345437, 64'h1010);
        check("lui_uimm", 64'(U_imm), 64'h12345);
        check("lui_dest", 64'(decode_dest_sel), 64'd8);
        check("lui_unsigned", 64'(comp_is_unsigned), 64'd0);

        // Unknown opcode passes through with no destination
        issue(32'h00000FFF, 64'h1014);
        check("unk_valid", 64'(decode_ack_data_valid), 64'd1);
        check("unk_op", 64'(op_code), 64'h7F);
        check("unk_dest", 64'(decode_dest_sel), 64'd0);

        // Bypass: ADD x4,x3,x0 with writeback to x3
        wb_rd_sel = 5'd3;
        wb_dest_enable = 1'b1;
        wb_dest = 64'hAB;
        issue(32'h00018233, 64'h1018);
        check("byp_src1", src1, 64'hAB);
        check("byp_src2", src2, 64'd0);
        wb_dest_enable = 1'b0;
        issue(32'h00018233, 64'h101C);
        check("nobyp_src1", src1, 64'd0);

        // Writeback to x0 must not bypass
        wb_rd_sel = 5'd0;
        wb_dest_enable = 1'b1;
        wb_dest = 64'h55;
        issue(32'h00000233, 64'h1020);
        check("byp_x0_src1", src1, 64'd0);
        wb_dest_enable = 1'b0;
        step();

        // Execute stalls 3 cycles while A,B,C are offered
        beat_instr[0] = 32'hFFF08293; beat_pc[0] = 64'h2000;
        beat_instr[1] = 32'h12345437; beat_pc[1] = 64'h2004;
        beat_instr[2] = 32'h001000EF; beat_pc[2] = 64'h2008;
        idx_f = 0;
        idx_e = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            execute_ack_data_rety = (cyc >= 1) && (cyc <= 3);
            if (idx_f < 3) begin
                fetch_valid = 1'b1;
                fetch_instr = beat_instr[idx_f];
                fetch_PC    = beat_pc[idx_f];
            end else begin
                fetch_valid = 1'b0;
            end
            #1;
            if (cyc == 1) check("stall_retry_c1", 64'(decode_ack_fetch_retry), SKID ? 64'd0 : 64'd1);
            if (cyc == 2 || cyc == 3) check("stall_retry", 64'(decode_ack_fetch_retry), 64'd1);
            if (cyc >= 1 && cyc <= 3) begin
                check("stall_hold_valid", 64'(decode_ack_data_valid), 64'd1);
                check("stall_hold_pc", PC, 64'h2000);
                check("stall_hold_op", 64'(op_code), 64'h13);
            end
            fire_f = fetch_valid && !decode_ack_fetch_retry;
            fire_e = decode_ack_data_valid && !execute_ack_data_rety;
            if (fire_e) begin
                if (idx_e < 3) begin
                    check("stall_order_pc", PC, beat_pc[idx_e]);
                    check("stall_order_op", 64'(op_code), 64'(beat_instr[idx_e][6:0]));
                end
                idx_e++;
            end
            step();
            if (fire_f) idx_f++;
        end
        execute_ack_data_rety = 1'b0;
        fetch_valid = 1'b0;
        check("stall_accepted", 64'(idx_f), 64'd3);
        check("stall_delivered", 64'(idx_e), 64'd3);

        // Flush drops the beat offered in the flush cycle
        flush = 1'b1;
        issue(32'h12345437, 64'h2100);
        flush = 1'b0;
        check("flush_valid", 64'(decode_ack_data_valid), 64'd0);

`ifdef DECODE_SKID_EN
        // A skid-held beat is discarded by flush
        issue(32'hFFF08293, 64'h3000);
        execute_ack_data_rety = 1'b1;
        issue(32'h12345437, 64'h3004);
        check("skid_retry", 64'(decode_ack_fetch_retry), 64'd1);
        flush = 1'b1;
        issue(32'h001000EF, 64'h3008);
        flush = 1'b0;
        check("skid_flush_hold_pc", PC, 64'h3000);
        check("skid_flush_retry", 64'(decode_ack_fetch_retry), 64'd0);
        execute_ack_data_rety = 1'b0;
        step();
        check("skid_flush_valid", 64'(decode_ack_data_valid), 64'd0);
`endif

        // Reset asserted mid-stall clears valid and retry without a clock edge
        issue(32'hFFF08293, 64'h4000);
        execute_ack_data_rety = 1'b1;
        fetch_valid = 1'b1;
        fetch_instr = 32'h12345437;
        fetch_PC = 64'h4004;
        step();
        step();
        check("midstall_retry_pre", 64'(decode_ack_fetch_retry), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(decode_ack_data_valid), 64'd0);
        check("midrst_retry", 64'(decode_ack_fetch_retry), 64'd0);
        check("midrst_pc", PC, 64'd0);
        #2;
        reset = 1'b1;
        execute_ack_data_rety = 1'b0;
        fetch_instr = 32'h12345437;
        fetch_PC = 64'h5000;
        step();
        fetch_valid = 1'b0;
        check("postrst_valid", 64'(decode_ack_data_valid), 64'd1);
        check("postrst_uimm", 64'(U_imm), 64'h12345);
        check("postrst_dest", 64'(decode_dest_sel), 64'd8);
        check("postrst_pc", PC, 64'h5000);
        step();
        check("postrst_idle", 64'(decode_ack_data_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
